// File: rtl/mode_counter_pkg.sv
// =============================================================================
// mode_counter_pkg : mode encodings, FSM states and a helper for mode_counter
// Rev 1.0
// =============================================================================
`default_nettype none

package mode_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // The reserved encoding behaves exactly like wrap.
  function automatic logic mode_is_wrap(input logic [1:0] m);
    return (m == MODE_WRAP) || (m == MODE_RSVD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// =============================================================================
// tick_prescaler : counts enabled cycles 0..prescale, ticking on the last one
// Rev 1.0
// =============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div;

  assign tick = (div == prescale);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (enable) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_counter.sv
// =============================================================================
// mode_counter : up/down counter with wrap, saturate and one-shot modes
// Optional tick divider: define MODE_COUNTER_PRESCALE_EN.  Rev 1.0
// =============================================================================
`default_nettype none

module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
`ifdef MODE_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      counter_out,
  output logic                  tc,
  output logic                  done
);

  state_t state;
  logic   tick;
  logic   terminal;

`ifdef MODE_COUNTER_PRESCALE_EN
  logic div_tick;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .clear    (load),
    .prescale (prescale),
    .tick     (div_tick)
  );

  assign tick = enable & div_tick;
`else
  logic [PRESCALE_W-1:0] unused_prescale_w;
  assign unused_prescale_w = '0;
  assign tick = enable;
`endif

  assign terminal = up ? (counter_out >= limit) : (counter_out == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_out <= '0;
      tc          <= 1'b0;
      done        <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      tc <= 1'b0;
      if (load) begin
        counter_out <= load_value;
        done        <= 1'b0;
        state       <= ST_RUN;
      end else if (tick) begin
        case (state)
          // A tick in DONE never counts; it only lets a mode change release the FSM.
          ST_DONE: begin
            if (mode != MODE_ONESHOT) begin
              state <= ST_RUN;
              done  <= 1'b0;
            end
          end
          default: begin
            state <= ST_RUN;
            if (terminal) begin
              tc <= 1'b1;
              if (mode == MODE_ONESHOT) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else if (mode_is_wrap(mode)) begin
                counter_out <= up ? '0 : limit;
              end
            end else begin
              counter_out <= up ? counter_out + 1'b1 : counter_out - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter PRESCALE_W, default 4, prescale value width in bits (used only with MODE_COUNTER_PRESCALE_EN).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1, count enable.
REQ-006 SHALL have port load, input, 1, synchronous load strobe.
REQ-007 SHALL have port load_value, input, WIDTH, value taken on load.
REQ-008 SHALL have port up, input, 1, direction (1 = up, 0 = down).
REQ-009 SHALL have port mode, input, 2, mode (00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap).
REQ-010 SHALL have port limit, input, WIDTH, upper terminal value.
REQ-011 SHALL have port prescale, input, PRESCALE_W, tick divider; present only with MODE_COUNTER_PRESCALE_EN.
REQ-012 SHALL have port counter_out, output, WIDTH, registered count.
REQ-013 SHALL have port tc, output, 1, registered terminal-count pulse.
REQ-014 SHALL have port done, output, 1, registered one-shot-complete flag.

Function
REQ-015 SHALL define tick = enable and prescaler tick (tick = enable without the macro).
REQ-016 SHALL give load priority over tick: load=1 sets counter_out = load_value on the next edge, with no count that cycle and tc=0.
REQ-017 SHALL define terminal as counter_out >= limit when up=1, and counter_out == 0 when up=0.
REQ-018 SHALL, on a non-terminal tick, change counter_out by +1 (up) or -1 (down) modulo 2^WIDTH, visible one edge after the tick is sampled.
REQ-019 SHALL, in wrap mode at a terminal tick, set counter_out to 0 (up) or to limit (down).
REQ-020 SHALL, in saturate mode at a terminal tick, hold counter_out.
REQ-021 SHALL assert tc for exactly one cycle, on the edge that processes a terminal tick, in every mode; tc=0 otherwise.
REQ-022 SHALL implement FSM states IDLE, RUN and DONE.
REQ-023 SHALL move the FSM from IDLE to RUN on the first tick or load.
REQ-024 SHALL move the FSM from RUN to DONE on a one-shot-mode terminal tick; counter_out holds and done=1.
REQ-025 SHALL, in DONE, ignore ticks; load sets RUN with done=0; a mode change to non-one-shot sets RUN with done=0.
REQ-026 SHALL handle limit=0 with up=1: every tick is terminal; wrap holds 0 and pulses tc every tick.
REQ-027 SHALL take no action when enable=0 and load=0: counter_out, FSM and prescaler all hold.
REQ-028 SHALL apply direction and mode changes from the next tick, with no glitch on the outputs.

Reset
REQ-029 SHALL, while reset=0 asynchronously, force counter_out=0, tc=0, done=0, FSM=IDLE and the prescaler divider to 0, including mid-count and mid-prescale.
REQ-030 SHALL resume on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with MODE_COUNTER_PRESCALE_EN defined, include the prescale port and a divider that counts enabled cycles 0..prescale, issuing a tick when the divider equals prescale and then clearing.
REQ-032 SHALL treat prescale=0 as a tick every enabled cycle; load clears the divider.
REQ-033 SHALL, without MODE_COUNTER_PRESCALE_EN, have no prescale port and no divider logic; tick = enable.

Structure
REQ-034 SHALL put mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and FSM state encodings in shared package mode_counter_pkg.
REQ-035 SHALL implement the divider as sub-module tick_prescaler, instantiated only under MODE_COUNTER_PRESCALE_EN.

Verification
REQ-036 SHALL cover wrap, up: WIDTH=4, limit=9, enable=1 -> counter_out 0,1..9,0; one tc pulse per wrap.
REQ-037 SHALL cover saturate, down: load 3, up=0 -> 2,1,0,0,0; tc on each tick at 0.
REQ-038 SHALL cover one-shot: load 0, limit=5 -> counts to 5, done=1 and holds; load 2 -> done=0 and counting resumes from 2.
REQ-039 SHALL cover load over enable: load=1, enable=1, load_value=7 at count 4 -> next value 7, not 5.
REQ-040 SHALL cover async reset mid-count: reset=0 at count 6 between edges -> counter_out=0 immediately; done=0; FSM=IDLE.
REQ-041 SHALL cover the prescaler (macro on): prescale=2, enable=1 -> counter_out increments every 3rd cycle; enable=0 freezes the divider.
